// File: rtl/imem_boot_loader_pkg.sv
// Shared encodings for the instruction-memory boot loader: FSM states, error codes
// and word geometry.
package imem_boot_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR0  = 3'd1;
  localparam logic [2:0] ST_HDR1  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_CKSUM = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_HDR0  = ST_HDR0,
    S_HDR1  = ST_HDR1,
    S_DATA  = ST_DATA,
    S_CKSUM = ST_CKSUM,
    S_DONE  = ST_DONE,
    S_ERR   = ST_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SIZE    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CKSUM   = 2'd3;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_if.sv
// UART byte stream in, imem write port out. The loader uses the slave modport;
// the byte source / memory side uses master.
interface imem_boot_loader_if #(
  parameter int AW = 9
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (output rx_data, output rx_valid,
                  input imem_we, input imem_addr, input imem_wdata);
  modport slave  (input rx_data, input rx_valid,
                  output imem_we, output imem_addr, output imem_wdata);
endinterface

// File: rtl/imem_boot_loader_packer.sv
// Packs bytes MSB-first into 32-bit words; word_ready_o pulses combinationally with
// the 4th byte, and word_o then holds the complete word including that byte.
module imem_word_packer
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        vld_i,
  input  logic [7:0]  rx_byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr_i) begin
      cnt_d = 2'd0;
    end else if (vld_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], rx_byte_i};
    end
  end

  assign word_o       = {shift_q, rx_byte_i};
  assign word_ready_o = vld_i && !clr_i && (cnt_q == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 2'd0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end
endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a word-count header plus big-endian payload and writes it into
// imem while holding the CPU. Define IMEM_BOOT_CKSUM_EN to require a trailing XOR byte.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int AW          = 9,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               boot_mode,
  imem_boot_loader_if.slave  bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code
);
  localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [15:0] DEPTH16  = 16'(DEPTH);
`ifdef IMEM_BOOT_CKSUM_EN
  localparam state_e      S_FINAL  = S_CKSUM;
`else
  localparam state_e      S_FINAL  = S_DONE;
`endif

  state_e          state_q, state_d;
  logic [15:0]     n_q, n_d, n_new;
  logic [15:0]     wcnt_q, wcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            tmo_on;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      code_q, code_d;
  logic            done_q, hold_q, error_q;
  logic [31:0]     word;
  logic            word_ready;
`ifdef IMEM_BOOT_CKSUM_EN
  logic [7:0]      cks_q, cks_d;
`endif

  imem_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (state_q != S_DATA),
    .vld_i        (bus.rx_valid),
    .rx_byte_i    (bus.rx_data),
    .word_o       (word),
    .word_ready_o (word_ready)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    tmo_d   = '0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    code_d  = code_q;
`ifdef IMEM_BOOT_CKSUM_EN
    cks_d   = cks_q;
`endif
    n_new   = {n_q[15:8], bus.rx_data};
    tmo_on  = (state_q == S_HDR1) || (state_q == S_DATA) || (state_q == S_CKSUM);
    if (tmo_on && !bus.rx_valid) tmo_d = tmo_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        wcnt_d  = '0;
`ifdef IMEM_BOOT_CKSUM_EN
        cks_d   = 8'h00;
`endif
        state_d = boot_mode ? S_HDR0 : S_DONE;
      end
      S_HDR0: if (bus.rx_valid) begin
        n_d     = {bus.rx_data, n_q[7:0]};
        state_d = S_HDR1;
      end
      S_HDR1: if (bus.rx_valid) begin
        n_d    = n_new;
        wcnt_d = '0;
        if (n_new > DEPTH16) begin
          state_d = S_ERR;
          code_d  = ERR_SIZE;
        end else if (n_new == 16'd0) begin
          state_d = S_FINAL;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
`ifdef IMEM_BOOT_CKSUM_EN
        if (bus.rx_valid) cks_d = cks_q ^ bus.rx_data;
`endif
        if (word_ready) begin
          we_d    = 1'b1;
          addr_d  = wcnt_q[AW-1:0];
          wdata_d = word;
          wcnt_d  = wcnt_q + 16'd1;
          if (wcnt_d == n_q) state_d = S_FINAL;
        end
      end
`ifdef IMEM_BOOT_CKSUM_EN
      S_CKSUM: if (bus.rx_valid) begin
        if (bus.rx_data == cks_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ERR;
          code_d  = ERR_CKSUM;
        end
      end
`endif
      S_DONE, S_ERR: state_d = state_q;
      default:       state_d = S_IDLE;
    endcase

    // An arriving byte always beats an expiring timeout.
    if (tmo_on && !bus.rx_valid && (tmo_q == TMO_LAST)) begin
      state_d = S_ERR;
      code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      code_q  <= ERR_NONE;
      done_q  <= 1'b0;
      hold_q  <= 1'b1;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      code_q  <= code_d;
      done_q  <= (state_d == S_DONE);
      hold_q  <= (state_d != S_DONE);
      error_q <= (state_d == S_ERR);
    end
  end

  always_ff @(posedge clk) begin
    n_q   <= n_d;
`ifdef IMEM_BOOT_CKSUM_EN
    cks_q <= cks_d;
`endif
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_hold       = hold_q;
  assign done           = done_q;
  assign error          = error_q;
  assign err_code       = code_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table of frame scenarios plus hand-built corner cases;
// expected imem writes go through a scoreboard queue checked by a write monitor.
module tb_imem_boot_loader;
  localparam int T = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       boot_mode = 1'b0;
  logic       cpu_hold, done, error;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [8:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  logic [7:0] cks;

  imem_boot_loader_if #(.AW(9)) bus ();

  imem_boot_loader #(.DEPTH(512), .AW(9), .TIMEOUT_CYC(T)) dut (
    .clk      (clk),
    .reset    (reset),
    .boot_mode(boot_mode),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every imem write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.imem_addr !== e.addr || bus.imem_wdata !== e.data) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   bus.imem_addr, bus.imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic send_payload_byte(input logic [7:0] b);
    cks = cks ^ b;
    send_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [8:0] a);
    wr_t e;
    e.addr = a;
    e.data = w;
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) send_payload_byte(w[31-8*k -: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic mode);
    reset     = 1'b1;
    boot_mode = mode;
    cks       = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check("rst_we", bus.imem_we, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_wdata", bus.imem_wdata, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_code", err_code, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(1);
  endtask

  task automatic check_end(input string tag, input logic e_done, input logic e_err,
                           input logic [1:0] e_code);
    idle(2);
    check({tag, "_done"}, done, e_done);
    check({tag, "_hold"}, cpu_hold, !e_done);
    check({tag, "_error"}, error, e_err);
    check({tag, "_code"}, err_code, e_code);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  typedef struct {
    logic        mode;
    logic [15:0] n;
    int          nsend;
    logic        e_done;
    logic        e_err;
    logic [1:0]  e_code;
  } vec_t;

  vec_t vec[7];

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    vec[0] = '{1'b0, 16'd0,     0,   1'b1, 1'b0, 2'd0};
    vec[1] = '{1'b1, 16'd1,     1,   1'b1, 1'b0, 2'd0};
    vec[2] = '{1'b1, 16'd3,     3,   1'b1, 1'b0, 2'd0};
    vec[3] = '{1'b1, 16'd513,   0,   1'b0, 1'b1, 2'd1};
    vec[4] = '{1'b1, 16'd0,     0,   1'b1, 1'b0, 2'd0};
    vec[5] = '{1'b1, 16'd512,   512, 1'b1, 1'b0, 2'd0};
    vec[6] = '{1'b1, 16'hFFFF,  0,   1'b0, 1'b1, 2'd1};

    // Table-driven frames; trailing junk must be ignored in DONE and ERR.
    for (int i = 0; i < 7; i++) begin
      do_reset(vec[i].mode);
      if (vec[i].mode) begin
        send_byte(vec[i].n[15:8]);
        send_byte(vec[i].n[7:0]);
        for (int w = 0; w < vec[i].nsend; w++) send_word($urandom, 9'(w));
`ifdef IMEM_BOOT_CKSUM_EN
        if (!vec[i].e_err) send_byte(cks);
`endif
      end
      repeat (4) send_byte(8'hA5);
      check_end($sformatf("vec%0d", i), vec[i].e_done, vec[i].e_err, vec[i].e_code);
    end

    // Skip mode: released within two cycles of reset.
    reset = 1'b1; boot_mode = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(2);
    check("skip_done", done, 1);
    check("skip_hold", cpu_hold, 0);

    // Reference frame, with write latency checked on the first word.
    do_reset(1'b1);
    send_byte(8'h00); send_byte(8'h02);
    begin
      wr_t e;
      e.addr = 9'd0; e.data = 32'h2009003F; exp_q.push_back(e);
      send_payload_byte(8'h20); send_payload_byte(8'h09); send_payload_byte(8'h00);
      send_payload_byte(8'h3F);
      @(negedge clk);
      check("latency_we", bus.imem_we, 1);
      #1;
      send_word(32'hAD090000, 9'd1);
    end
`ifdef IMEM_BOOT_CKSUM_EN
    check("ref_cks_val", cks, 8'hB2);
    send_byte(cks);
`endif
    check_end("ref", 1'b1, 1'b0, 2'd0);

    // Timeout after two payload bytes: no write, error code 2.
    do_reset(1'b1);
    send_byte(8'h00); send_byte(8'h01);
    send_payload_byte(8'h12); send_payload_byte(8'h34);
    idle(T);
    send_payload_byte(8'h56); send_payload_byte(8'h78);
    check_end("tmo", 1'b0, 1'b1, 2'd2);

    // One cycle short of the timeout: load still completes.
    do_reset(1'b1);
    send_byte(8'h00); send_byte(8'h01);
    begin
      wr_t e;
      e.addr = 9'd0; e.data = 32'h12345678; exp_q.push_back(e);
      send_payload_byte(8'h12); send_payload_byte(8'h34);
      idle(T - 1);
      send_payload_byte(8'h56); send_payload_byte(8'h78);
    end
`ifdef IMEM_BOOT_CKSUM_EN
    send_byte(cks);
`endif
    check_end("tmo_edge", 1'b1, 1'b0, 2'd0);

    // Reset after five payload bytes, then a clean N=1 frame.
    do_reset(1'b1);
    send_byte(8'h00); send_byte(8'h02);
    send_word(32'hCAFEF00D, 9'd0);
    send_payload_byte(8'h99);
    idle(1);
    check("midrst_pending", exp_q.size(), 0);
    do_reset(1'b1);
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'h0BADBEEF, 9'd0);
`ifdef IMEM_BOOT_CKSUM_EN
    send_byte(cks);
`endif
    check_end("midrst", 1'b1, 1'b0, 2'd0);

`ifdef IMEM_BOOT_CKSUM_EN
    // Bad checksum: 0x00^0x00^0x40^0x20 = 0x60, frame carries 0x61.
    do_reset(1'b1);
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'h00004020, 9'd0);
    send_byte(8'h61);
    check_end("badcks", 1'b0, 1'b1, 2'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
